mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 120 ++++++++++++
 tb/tb_mem_responder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-port memory responder with a four-phase REQ/ACK handshake and a fixed wait.
// The memory is flop-based so that reset can clear every word.
module mem_responder #(
  parameter int AW   = 4,
  parameter int DW   = 16,
  parameter int WAIT = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          REQ,
  input  logic          WE,
  input  logic [AW-1:0] ADDR,
  input  logic [DW-1:0] WDATA,
  output logic          ACK,
  output logic [DW-1:0] RDATA,
  output logic          BUSY,
  output logic          ABORT
);
  localparam int DEPTH = 1 << AW;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_RELEASE} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic          we_l;
  logic [AW-1:0] addr_l;
  logic [DW-1:0] wdata_l;
  logic [DW-1:0] mem [DEPTH];

  logic          go_resp;
  logic          acc_we;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;

  // With no wait the access happens on the sampling edge, so the live inputs
  // are used there; otherwise the latched copies drive the access.
  always_comb begin
    go_resp   = 1'b0;
    acc_we    = we_l;
    acc_addr  = addr_l;
    acc_wdata = wdata_l;
    if (state == S_IDLE) begin
      go_resp   = REQ && (WAIT_CNT == 4'd0);
      acc_we    = WE;
      acc_addr  = ADDR;
      acc_wdata = WDATA;
    end else if (state == S_WAIT) begin
      go_resp   = REQ && (cnt == 4'd1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      we_l    <= 1'b0;
      addr_l  <= '0;
      wdata_l <= '0;
      ACK     <= 1'b0;
      ABORT   <= 1'b0;
      BUSY    <= 1'b0;
      RDATA   <= '0;
    end else begin
      ACK   <= 1'b0;
      ABORT <= 1'b0;
      if (go_resp && !acc_we) RDATA <= mem[acc_addr];
      case (state)
        S_IDLE: if (REQ) begin
          we_l    <= WE;
          addr_l  <= ADDR;
          wdata_l <= WDATA;
          cnt     <= WAIT_CNT;
          BUSY    <= 1'b1;
          if (go_resp) begin
            state <= S_RESP;
            ACK   <= 1'b1;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!REQ) begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
            ABORT <= 1'b1;
            cnt   <= '0;
          end else if (go_resp) begin
            state <= S_RESP;
            ACK   <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt   <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          state <= REQ ? S_RELEASE : S_IDLE;
          BUSY  <= REQ;
        end
        S_RELEASE: if (!REQ) begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (go_resp && acc_we) begin
      mem[acc_addr] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: instance 0 runs with WAIT=2, instance 1 with WAIT=0.
// Expected behaviour comes from a transaction-level model (memory array + last read word).
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req   [2];
  logic        we    [2];
  logic [3:0]  addr  [2];
  logic [15:0] wdata [2];
  logic        ack   [2];
  logic [15:0] rdata [2];
  logic        busy  [2];
  logic        abort [2];

  int tests = 0;
  int failed = 0;

  logic [15:0] mem_m [2][16];
  logic [15:0] rd_m  [2];

  always #5 clk = ~clk;

  mem_responder #(.AW(4), .DW(16), .WAIT(2)) u_w2 (
    .clk(clk), .reset_n(reset_n), .REQ(req[0]), .WE(we[0]), .ADDR(addr[0]),
    .WDATA(wdata[0]), .ACK(ack[0]), .RDATA(rdata[0]), .BUSY(busy[0]), .ABORT(abort[0]));

  mem_responder #(.AW(4), .DW(16), .WAIT(0)) u_w0 (
    .clk(clk), .reset_n(reset_n), .REQ(req[1]), .WE(we[1]), .ADDR(addr[1]),
    .WDATA(wdata[1]), .ACK(ack[1]), .RDATA(rdata[1]), .BUSY(busy[1]), .ABORT(abort[1]));

  typedef struct {
    int          inst;
    bit          w;
    logic [3:0]  a;
    logic [15:0] d;
    int          h;       // edges after the sampling edge that REQ stays high
    int          exp_ack;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vt[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      rd_m[i] = '0;
      for (int j = 0; j < 16; j++) mem_m[i][j] = '0;
    end
  endtask

  // One transaction: completes iff REQ survives the wait, ACK lands WAIT edges after
  // the sampling edge, BUSY covers every edge REQ was high, ABORT follows the drop.
  task automatic run_txn(input int i, input bit w, input logic [3:0] a, input logic [15:0] d,
                         input int h, output int nack, output logic [15:0] rd_at_ack);
    int wt;
    bit done;
    wt = (i == 0) ? 2 : 0;
    done = (h >= wt);
    nack = 0;
    rd_at_ack = '0;
    @(negedge clk);
    req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
    for (int k = 0; k <= h + 2; k++) begin
      @(posedge clk); #1;
      if (done && k == wt) begin
        if (w) mem_m[i][a] = d;
        else   rd_m[i] = mem_m[i][a];
      end
      check("ack",   ack[i],   done && k == wt);
      check("abort", abort[i], !done && k == h + 1);
      check("busy",  busy[i],  k <= h);
      check("rdata", rdata[i], rd_m[i]);
      if (ack[i]) begin
        nack++;
        rd_at_ack = rdata[i];
      end
      @(negedge clk);
      if (k == h) req[i] = 1'b0;
      we[i] = 1'($urandom); addr[i] = 4'($urandom); wdata[i] = 16'($urandom);
    end
  endtask

  initial begin
    int nack;
    logic [15:0] rd;

    vt[0]  = '{0, 1'b1, 4'h3, 16'hBEEF, 2, 1, 16'h0000};
    vt[1]  = '{0, 1'b0, 4'h3, 16'h0000, 2, 1, 16'hBEEF};
    vt[2]  = '{0, 1'b0, 4'h4, 16'h0000, 2, 1, 16'h0000};
    vt[3]  = '{0, 1'b0, 4'h3, 16'h0000, 7, 1, 16'hBEEF};
    vt[4]  = '{0, 1'b1, 4'h5, 16'h1234, 1, 0, 16'h0000};
    vt[5]  = '{0, 1'b0, 4'h5, 16'h0000, 2, 1, 16'h0000};
    vt[6]  = '{0, 1'b1, 4'h5, 16'h1234, 0, 0, 16'h0000};
    vt[7]  = '{0, 1'b0, 4'h3, 16'h0000, 3, 1, 16'hBEEF};
    vt[8]  = '{1, 1'b1, 4'h2, 16'hABCD, 0, 1, 16'h0000};
    vt[9]  = '{1, 1'b0, 4'h2, 16'h0000, 0, 1, 16'hABCD};
    vt[10] = '{1, 1'b0, 4'h2, 16'h0000, 3, 1, 16'hABCD};

    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
    clear_model();

    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_ack",   ack[i],   0);
      check("rst_abort", abort[i], 0);
      check("rst_busy",  busy[i],  0);
      check("rst_rdata", rdata[i], 0);
    end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    for (int t = 0; t < 11; t++) begin
      run_txn(vt[t].inst, vt[t].w, vt[t].a, vt[t].d, vt[t].h, nack, rd);
      check("tbl_nack", nack, vt[t].exp_ack);
      if (!vt[t].w && vt[t].exp_ack != 0) check("tbl_rdata", rd, vt[t].exp_rd);
    end

    // Reset dropped in the middle of a write's wait period.
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 4'h7; wdata[0] = 16'h5555;
    @(posedge clk);
    @(posedge clk); #3;
    reset_n = 1'b0;
    req[0] = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("arst_ack",   ack[i],   0);
      check("arst_abort", abort[i], 0);
      check("arst_busy",  busy[i],  0);
      check("arst_rdata", rdata[i], 0);
    end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    clear_model();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("post_rst_ack",   ack[0],   0);
      check("post_rst_abort", abort[0], 0);
      check("post_rst_busy",  busy[0],  0);
    end
    run_txn(0, 1'b0, 4'h7, 16'h0, 2, nack, rd);
    check("rst_nowrite", rd, 16'h0000);
    run_txn(0, 1'b0, 4'h3, 16'h0, 2, nack, rd);
    check("rst_memclr", rd, 16'h0000);
    run_txn(1, 1'b0, 4'h2, 16'h0, 0, nack, rd);
    check("rst_memclr1", rd, 16'h0000);
    run_txn(0, 1'b1, 4'h7, 16'h5555, 2, nack, rd);
    check("rst_wr_nack", nack, 1);
    run_txn(0, 1'b0, 4'h7, 16'h0, 2, nack, rd);
    check("rst_rdback", rd, 16'h5555);

    for (int n = 0; n < 200; n++) begin
      run_txn(int'($urandom_range(0, 1)), 1'($urandom), 4'($urandom), 16'($urandom),
              int'($urandom_range(0, 5)), nack, rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
